// File: rtl/count_event_capture.sv
// Compare-and-capture stage for the free-running count bus: matches feed a small FIFO drained over valid/ready.
// Optional build macro EVT_SEQ_TAG_EN adds an 8-bit per-match sequence tag (evt_seq) stored with each entry.
module count_event_capture #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   count,
   input  logic          arm,
   input  logic          disarm,
   input  logic [31:0]   cmp_init,
   input  logic [31:0]   period,
   input  logic          clear_ovf,
   output logic          armed,
   output logic          evt_valid,
   output logic [31:0]   evt_data,
   input  logic          evt_ready,
   output logic          overflow,
   output logic [AW:0]   fifo_level
`ifdef EVT_SEQ_TAG_EN
   ,
   output logic [7:0]    evt_seq
`endif
);

   localparam int unsigned DW = 32;
   localparam int unsigned PW = AW + 1;

   typedef enum logic {IDLE, ARMED} state_t;

   state_t        state;
   logic [DW-1:0] cmp_reg;
   logic [DW-1:0] per_reg;
   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic          match;
   logic          full;
   logic          pop;
   logic          push;
   logic          ovf_set;
   logic          head_bypass;
   logic [PW-1:0] next_wr;
   logic [PW-1:0] next_rd;

   // Match, FIFO handshake and next-pointer decode
   always_comb begin
      match       = (state == ARMED) && (count == cmp_reg);
      full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop         = evt_valid && evt_ready;
      push        = match && (!full || pop);
      ovf_set     = match && full && !pop;
      next_wr     = wr_ptr + PW'(push);
      next_rd     = rd_ptr + PW'(pop);
      // a push landing on the new head slot must be forwarded, the memory is not yet written
      head_bypass = push && (wr_ptr == next_rd);
   end

   // Arm/disarm control; a match uses the compare point in force this cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         armed   <= 1'b0;
         cmp_reg <= '0;
         per_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  state   <= ARMED;
                  armed   <= 1'b1;
                  cmp_reg <= cmp_init;
                  per_reg <= period;
               end
            end
            ARMED: begin
               if (arm) begin
                  cmp_reg <= cmp_init;
                  per_reg <= period;
               end else if (disarm) begin
                  state <= IDLE;
                  armed <= 1'b0;
               end else if (match) begin
                  cmp_reg <= cmp_reg + per_reg;
                  if (per_reg == '0) begin
                     state <= IDLE;
                     armed <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               armed <= 1'b0;
            end
         endcase
      end
   end

   // Pointers, occupancy, head register and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         evt_valid  <= 1'b0;
         evt_data   <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         wr_ptr     <= next_wr;
         rd_ptr     <= next_rd;
         evt_valid  <= (next_wr != next_rd);
         fifo_level <= next_wr - next_rd;
         if (next_wr != next_rd)
            evt_data <= head_bypass ? count : mem[next_rd[AW-1:0]];
         if (ovf_set)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= count;
   end

`ifdef EVT_SEQ_TAG_EN
   logic [7:0] seq_cnt;
   logic [7:0] tag_mem [DEPTH];

   // Tag advances on every match, dropped or not, so gaps reveal losses
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_cnt <= '0;
         evt_seq <= '0;
      end else begin
         if (match)
            seq_cnt <= seq_cnt + 8'd1;
         if (next_wr != next_rd)
            evt_seq <= head_bypass ? seq_cnt : tag_mem[next_rd[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         tag_mem[wr_ptr[AW-1:0]] <= seq_cnt;
   end
`endif

endmodule

// File: tb/tb_count_event_capture.sv
// Directed bench for count_event_capture: stimulus queues expected events, a negedge monitor checks them.
module tb_count_event_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] count = '0;
   logic        arm = 1'b0;
   logic        disarm = 1'b0;
   logic [31:0] cmp_init = '0;
   logic [31:0] period = '0;
   logic        clear_ovf = 1'b0;
   logic        armed;
   logic        evt_valid;
   logic [31:0] evt_data;
   logic        evt_ready = 1'b0;
   logic        overflow;
   logic [2:0]  fifo_level;
`ifdef EVT_SEQ_TAG_EN
   logic [7:0]  evt_seq;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [39:0] sb [$];
   logic [39:0] mon_exp;

   count_event_capture #(.DEPTH(4), .AW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .count      (count),
      .arm        (arm),
      .disarm     (disarm),
      .cmp_init   (cmp_init),
      .period     (period),
      .clear_ovf  (clear_ovf),
      .armed      (armed),
      .evt_valid  (evt_valid),
      .evt_data   (evt_data),
      .evt_ready  (evt_ready),
      .overflow   (overflow),
      .fifo_level (fifo_level)
`ifdef EVT_SEQ_TAG_EN
      ,
      .evt_seq    (evt_seq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input logic [7:0] tag, input logic [31:0] d);
      sb.push_back({tag, d});
   endtask

   // Scoreboard monitor: every accepted head must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got 0x%0h expected none", evt_data);
         end else begin
            mon_exp = sb.pop_front();
            chk("evt_data", evt_data, mon_exp[31:0]);
`ifdef EVT_SEQ_TAG_EN
            chk("evt_seq", {24'd0, evt_seq}, {24'd0, mon_exp[39:32]});
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_data", evt_data, 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);

      // one-shot at 10
      evt_ready = 1'b1;
      count = 0; cmp_init = 10; period = 0; arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("os_armed", 32'(armed), 32'd1);
      for (int c = 1; c <= 13; c++) begin
         count = 32'(c);
         if (c == 10) expect_evt(8'd0, 32'd10);
         tick();
         if (c == 10) begin
            chk("os_armed_drop", 32'(armed), 32'd0);
            chk("os_valid", 32'(evt_valid), 32'd1);
            chk("os_data", evt_data, 32'd10);
         end
         if (c == 11) chk("os_pulse_end", 32'(evt_valid), 32'd0);
      end

      // periodic through the 32-bit wrap, then disarm
      count = 32'hFFFF_FFFC; cmp_init = 32'hFFFF_FFFE; period = 4; arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 12; i++) begin
         count = 32'hFFFF_FFFD + 32'(i);
         if (count == 32'hFFFF_FFFE) expect_evt(8'd1, 32'hFFFF_FFFE);
         if (count == 32'h0000_0002) expect_evt(8'd2, 32'h0000_0002);
         if (count == 32'h0000_0006) expect_evt(8'd3, 32'h0000_0006);
         tick();
      end
      chk("per_still_armed", 32'(armed), 32'd1);
      count = 9; disarm = 1'b1;
      tick();
      disarm = 1'b0;
      chk("disarm_armed", 32'(armed), 32'd0);
      count = 10; tick();
      count = 11; tick();
      chk("disarm_no_evt", 32'(fifo_level), 32'd0);

      // reset with three queued events
      evt_ready = 1'b0;
      count = 49; cmp_init = 50; period = 1; arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 3; i++) begin
         count = 50 + 32'(i);
         tick();
      end
      chk("pre_rst_level", 32'(fifo_level), 32'd3);
      count = 53; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", 32'(evt_valid), 32'd0);
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_armed", 32'(armed), 32'd0);
      chk("mid_rst_data", evt_data, 32'd0);

      // overflow: six matches into a four-entry FIFO
      count = 99; cmp_init = 100; period = 1; arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 6; i++) begin
         count = 100 + 32'(i);
         if (i < 4) expect_evt(8'(i), 100 + 32'(i));
         tick();
      end
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_head", evt_data, 32'd100);
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      chk("ovf_sticky", 32'(overflow), 32'd1);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      chk("ovf_clear", 32'(overflow), 32'd0);
      evt_ready = 1'b1;
      repeat (4) tick();
      evt_ready = 1'b0;
      chk("drain_level", 32'(fifo_level), 32'd0);
      chk("drain_valid", 32'(evt_valid), 32'd0);
      chk("drain_hold", evt_data, 32'd103);

      // next accepted event after the drops
      evt_ready = 1'b1;
      count = 199; cmp_init = 200; period = 0; arm = 1'b1;
      tick();
      arm = 1'b0;
      count = 200; expect_evt(8'd6, 32'd200);
      tick();
      count = 201; tick();
      tick();

      // full FIFO with push and pop in the same cycle
      evt_ready = 1'b0;
      count = 299; cmp_init = 300; period = 1; arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 4; i++) begin
         count = 300 + 32'(i);
         expect_evt(8'(7 + i), 300 + 32'(i));
         tick();
      end
      chk("full_level", 32'(fifo_level), 32'd4);
      count = 304; evt_ready = 1'b1; expect_evt(8'd11, 32'd304);
      tick();
      evt_ready = 1'b0;
      chk("pp_level", 32'(fifo_level), 32'd4);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", evt_data, 32'd301);
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      evt_ready = 1'b1;
      repeat (5) tick();
      evt_ready = 1'b0;
      chk("pp_drained", 32'(fifo_level), 32'd0);

      // arm and disarm together: arm wins
      count = 0; cmp_init = 32'h1000; period = 0; arm = 1'b1; disarm = 1'b1;
      tick();
      arm = 1'b0; disarm = 1'b0;
      chk("arm_wins", 32'(armed), 32'd1);
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      chk("final_disarm", 32'(armed), 32'd0);

      tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
